// File: rtl/xgmii_enc_tx.sv
// XGMII/XLGMII to 64b/66b transmit block encoder with the transmit
// sequencing state machine and a saturating error-block counter.
module xgmii_enc_tx #(
   parameter bit IS_40G = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      xgmii_txd_i,
   input  logic [7:0]       xgmii_txc_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [1:0]       head_o,
   output logic [63:0]      data_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   typedef enum logic [2:0] {
      TX_INIT = 3'd0,
      TX_C    = 3'd1,
      TX_D    = 3'd2,
      TX_T    = 3'd3,
      TX_E    = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      T_D = 3'd0,
      T_C = 3'd1,
      T_S = 3'd2,
      T_T = 3'd3,
      T_E = 3'd4
   } blk_type_t;

   localparam logic [63:0]      EBLOCK  = {{8{7'h1E}}, 8'h1E};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic is_ie(input logic [7:0] b);
      is_ie = (b == 8'h07) || (b == 8'hFE);
   endfunction

   function automatic logic [6:0] ctl_code(input logic [7:0] b);
      case (b)
         8'h07:   ctl_code = 7'h00;
         8'hFE:   ctl_code = 7'h1E;
         default: ctl_code = 7'h1E;
      endcase
   endfunction

   function automatic logic [7:0] t_btype(input logic [2:0] i);
      case (i)
         3'd0:    t_btype = 8'h87;
         3'd1:    t_btype = 8'h99;
         3'd2:    t_btype = 8'hAA;
         3'd3:    t_btype = 8'hB4;
         3'd4:    t_btype = 8'hCC;
         3'd5:    t_btype = 8'hD2;
         3'd6:    t_btype = 8'hE1;
         3'd7:    t_btype = 8'hFF;
         default: t_btype = 8'hFF;
      endcase
   endfunction

   tx_state_t        state_q, state_d;
   logic             valid_q, valid_d;
   logic [1:0]       head_q, head_d;
   logic [63:0]      data_q, data_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic             accept_s;
   logic             all_ie_s, lo_ie_s, s4_s;
   logic             t_ok_s, t_hit_s;
   logic [2:0]       t_idx_s;
   logic [63:0]      c_blk_s, t_mask_s, t_blk_s;
   blk_type_t        typ_s;
   logic [1:0]       norm_head_s;
   logic [63:0]      norm_data_s;
   logic             blk_ok_s;

   assign ready_o  = ~valid_q | ready_i;
   assign accept_s = valid_i & ready_o;

   // Classify the presented word and build its normal (non-error) block.
   always_comb begin
      all_ie_s = 1'b1;
      c_blk_s  = 64'd0;
      c_blk_s[7:0] = 8'h1E;
      for (int k = 0; k < 8; k++) begin
         all_ie_s = all_ie_s & is_ie(xgmii_txd_i[8*k +: 8]);
         c_blk_s[8+7*k +: 7] = ctl_code(xgmii_txd_i[8*k +: 8]);
      end
      lo_ie_s = is_ie(xgmii_txd_i[7:0])   & is_ie(xgmii_txd_i[15:8]) &
                is_ie(xgmii_txd_i[23:16]) & is_ie(xgmii_txd_i[31:24]);

      // Terminate in lane i: data below, 0xFD at i, only IDLE above.
      t_ok_s  = 1'b0;
      t_hit_s = 1'b0;
      t_idx_s = 3'd0;
      for (int i = 0; i < 8; i++) begin
         t_ok_s = (xgmii_txc_i == (8'hFF << i)) && (xgmii_txd_i[8*i +: 8] == 8'hFD);
         for (int j = i + 1; j < 8; j++) begin
            t_ok_s = t_ok_s & (xgmii_txd_i[8*j +: 8] == 8'h07);
         end
         t_idx_s = t_ok_s ? 3'(i) : t_idx_s;
         t_hit_s = t_hit_s | t_ok_s;
      end
      t_mask_s = (64'd1 << {t_idx_s, 3'b000}) - 64'd1;
      t_blk_s  = ((xgmii_txd_i & t_mask_s) << 4'd8) | {56'd0, t_btype(t_idx_s)};

      s4_s        = 1'b0;
      norm_head_s = 2'b10;
      norm_data_s = EBLOCK;
      if (xgmii_txc_i == 8'h00) begin
         typ_s       = T_D;
         norm_head_s = 2'b01;
         norm_data_s = xgmii_txd_i;
      end else if ((xgmii_txc_i == 8'hFF) && all_ie_s) begin
         typ_s       = T_C;
         norm_data_s = c_blk_s;
      end else if ((xgmii_txc_i == 8'h01) && (xgmii_txd_i[7:0] == 8'hFB)) begin
         typ_s       = T_S;
         norm_data_s = {xgmii_txd_i[63:8], 8'h78};
      end else if (!IS_40G && (xgmii_txc_i == 8'h1F) && lo_ie_s &&
                   (xgmii_txd_i[39:32] == 8'hFB)) begin
         typ_s       = T_S;
         s4_s        = 1'b1;
         norm_data_s = {xgmii_txd_i[63:40], 4'h0, c_blk_s[35:8], 8'h33};
      end else if (t_hit_s) begin
         typ_s       = T_T;
         norm_data_s = t_blk_s;
      end else begin
         typ_s = T_E;
      end
   end

   // Sequence check, output register update and error counting.
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      head_d    = head_q;
      data_d    = data_q;
      err_cnt_d = err_cnt_q;
      blk_ok_s  = 1'b0;
      if (accept_s) begin
         case (state_q)
            TX_INIT, TX_C, TX_T: begin
               case (typ_s)
                  T_C:     begin state_d = TX_C; blk_ok_s = 1'b1; end
                  T_S:     begin state_d = TX_D; blk_ok_s = 1'b1; end
                  default: state_d = TX_E;
               endcase
            end
            TX_D: begin
               case (typ_s)
                  T_D:     begin state_d = TX_D; blk_ok_s = 1'b1; end
                  T_T:     begin state_d = TX_T; blk_ok_s = 1'b1; end
                  default: state_d = TX_E;
               endcase
            end
            TX_E: begin
               case (typ_s)
                  T_C:     begin state_d = TX_C; blk_ok_s = 1'b1; end
                  T_D:     begin state_d = TX_D; blk_ok_s = 1'b1; end
                  T_T:     begin state_d = TX_T; blk_ok_s = 1'b1; end
                  T_S:     begin state_d = TX_D; blk_ok_s = 1'b1; end
                  default: state_d = TX_E;
               endcase
            end
            default: state_d = TX_E;
         endcase
         valid_d = 1'b1;
         if (blk_ok_s) begin
            head_d = norm_head_s;
            data_d = norm_data_s;
         end else begin
            head_d = 2'b10;
            data_d = EBLOCK;
            err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_ONE;
         end
      end else if (ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= TX_INIT;
         valid_q   <= 1'b0;
         head_q    <= 2'b00;
         data_q    <= 64'd0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         head_q    <= head_d;
         data_q    <= data_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign valid_o   = valid_q;
   assign head_o    = head_q;
   assign data_o    = data_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_xgmii_enc_tx.sv
// Scoreboard bench for xgmii_enc_tx: an XLGMII instance (16-bit counter) and a
// 10G instance (2-bit counter) run the same directed vectors side by side.
module tb_xgmii_enc_tx;

   localparam logic [63:0] EBLK = 64'h3C78F1E3C78F1E1E;
   localparam logic [63:0] IDLE = 64'h0707070707070707;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] txd;
   logic [7:0]  txc;
   logic        valid_i, ready_i;
   logic        rdy40, vo40, rdy10, vo10;
   logic [1:0]  h40, h10;
   logic [63:0] d40, d10;
   logic [15:0] ec40;
   logic [1:0]  ec10;

   xgmii_enc_tx #(.IS_40G(1'b1), .CNT_W(16)) dut40 (
      .clk(clk), .rst(rst), .xgmii_txd_i(txd), .xgmii_txc_i(txc),
      .valid_i(valid_i), .ready_o(rdy40), .ready_i(ready_i), .valid_o(vo40),
      .head_o(h40), .data_o(d40), .err_cnt_o(ec40));

   xgmii_enc_tx #(.IS_40G(1'b0), .CNT_W(2)) dut10 (
      .clk(clk), .rst(rst), .xgmii_txd_i(txd), .xgmii_txc_i(txc),
      .valid_i(valid_i), .ready_o(rdy10), .ready_i(ready_i), .valid_o(vo10),
      .head_o(h10), .data_o(d10), .err_cnt_o(ec10));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  h40;
      logic [63:0] d40;
      logic [15:0] c40;
      logic [1:0]  h10;
      logic [63:0] d10;
      logic [1:0]  c10;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   logic [15:0] ecnt40 = 16'd0;
   logic [1:0]  ecnt10 = 2'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Push expectation, present the word, return 1 ns after the capturing edge.
   task automatic send(input logic [63:0] d, input logic [7:0] c,
                       input logic [1:0] eh40, input logic [63:0] ed40,
                       input logic [1:0] eh10, input logic [63:0] ed10);
      exp_t e;
      if (eh40 == 2'b10 && ed40 == EBLK) ecnt40 = ecnt40 + 16'd1;
      if (eh10 == 2'b10 && ed10 == EBLK && ecnt10 != 2'd3) ecnt10 = ecnt10 + 2'd1;
      e = '{eh40, ed40, ecnt40, eh10, ed10, ecnt10};
      q.push_back(e);
      txd = d; txc = c; valid_i = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send2(input logic [63:0] d, input logic [7:0] c,
                        input logic [1:0] eh, input logic [63:0] ed);
      send(d, c, eh, ed, eh, ed);
   endtask

   // Monitor: compare every block transferred downstream against the queue.
   always @(negedge clk) begin
      if (!rst && vo40 && ready_i) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_block: got %h want none", d40);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("head40", {62'd0, h40}, {62'd0, e.h40});
            check("data40", d40, e.d40);
            check("cnt40", {48'd0, ec40}, {48'd0, e.c40});
            check("valid10", {63'd0, vo10}, 64'd1);
            check("head10", {62'd0, h10}, {62'd0, e.h10});
            check("data10", d10, e.d10);
            check("cnt10", {62'd0, ec10}, {62'd0, e.c10});
         end
      end
   end

   logic [63:0] tv_d [8];
   logic [7:0]  tv_c [8];
   logic [63:0] tv_e [8];

   initial begin
      tv_d[0] = 64'h07070707070707FD; tv_c[0] = 8'hFF; tv_e[0] = 64'h0000000000000087;
      tv_d[1] = 64'h070707070707FD11; tv_c[1] = 8'hFE; tv_e[1] = 64'h0000000000001199;
      tv_d[2] = 64'h0707070707FD2211; tv_c[2] = 8'hFC; tv_e[2] = 64'h00000000002211AA;
      tv_d[3] = 64'h07070707FD332211; tv_c[3] = 8'hF8; tv_e[3] = 64'h00000000332211B4;
      tv_d[4] = 64'h070707FD44332211; tv_c[4] = 8'hF0; tv_e[4] = 64'h00000044332211CC;
      tv_d[5] = 64'h0707FD5544332211; tv_c[5] = 8'hE0; tv_e[5] = 64'h00005544332211D2;
      tv_d[6] = 64'h07FD665544332211; tv_c[6] = 8'hC0; tv_e[6] = 64'h00665544332211E1;
      tv_d[7] = 64'hFD77665544332211; tv_c[7] = 8'h80; tv_e[7] = 64'h77665544332211FF;

      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; txd = 64'd0; txc = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {62'd0, vo40, vo10}, 64'd0);
      check("rst_head", {60'd0, h40, h10}, 64'd0);
      check("rst_data", d40 | d10, 64'd0);
      check("rst_cnt", {46'd0, ec40, ec10}, 64'd0);
      rst = 1'b0;

      // Idle, idle with an ERROR lane, start, data, spec terminate example, idle.
      send2(IDLE, 8'hFF, 2'b10, 64'h000000000000001E);
      send2(64'h0707070707FE0707, 8'hFF, 2'b10, 64'h000000000780001E);
      send2(64'hD7D6D5D4D3D2D1FB, 8'h01, 2'b10, 64'hD7D6D5D4D3D2D178);
      send2(64'h1122334455667788, 8'h00, 2'b01, 64'h1122334455667788);
      send2(64'h07070707FDCCBBAA, 8'hF8, 2'b10, 64'h00000000CCBBAAB4);
      send2(IDLE, 8'hFF, 2'b10, 64'h000000000000001E);

      // Terminate sweep, each inside a short packet and followed by idle.
      for (int i = 0; i < 8; i++) begin
         send2(64'hD7D6D5D4D3D2D1FB, 8'h01, 2'b10, 64'hD7D6D5D4D3D2D178);
         send2(64'h0123456789ABCDEF, 8'h00, 2'b01, 64'h0123456789ABCDEF);
         send2(tv_d[i], tv_c[i], 2'b10, tv_e[i]);
         send2(IDLE, 8'hFF, 2'b10, 64'h000000000000001E);
      end

      // Data straight after idle, then ordered sets; the 2-bit counter saturates.
      send2(64'h0011223344556677, 8'h00, 2'b10, EBLK);
      send2(IDLE, 8'hFF, 2'b10, 64'h000000000000001E);
      for (int i = 0; i < 5; i++) begin
         send2(64'h000000000000009C, 8'h01, 2'b10, EBLK);
      end
      send2(IDLE, 8'hFF, 2'b10, 64'h000000000000001E);

      // Start on lane 4: error on XLGMII, 0x33 block on 10G; terminate realigns both.
      send(64'hA1A2A3FB0707FE07, 8'h1F, 2'b10, EBLK, 2'b10, 64'hA1A2A300000F0033);
      send2(tv_d[0], tv_c[0], 2'b10, tv_e[0]);
      send2(IDLE, 8'hFF, 2'b10, 64'h000000000000001E);

      // Backpressure for three cycles with a word waiting.
      send2(64'hD7D6D5D4D3D2D1FB, 8'h01, 2'b10, 64'hD7D6D5D4D3D2D178);
      ready_i = 1'b0;
      txd = 64'h1122334455667788; txc = 8'h00; valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready", {62'd0, rdy40, rdy10}, 64'd0);
         check("bp_valid", {62'd0, vo40, vo10}, 64'd3);
         check("bp_data", d40, 64'hD7D6D5D4D3D2D178);
         check("bp_cnt", {48'd0, ec40}, {48'd0, ecnt40});
      end
      @(posedge clk); #1;
      q.push_back('{2'b01, 64'h1122334455667788, ecnt40, 2'b01, 64'h1122334455667788, ecnt10});
      ready_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;

      // Asynchronous reset mid-packet, then a data word must be an error.
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_valid", {62'd0, vo40, vo10}, 64'd0);
      check("arst_data", d40, 64'd0);
      check("arst_cnt", {48'd0, ec40}, 64'd0);
      ecnt40 = 16'd0; ecnt10 = 2'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      send2(64'h8877665544332211, 8'h00, 2'b10, EBLK);
      send2(IDLE, 8'hFF, 2'b10, 64'h000000000000001E);
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
